// File: rtl/alu_sequencer_if.sv
// Control bundle between instruction decode / ALU datapath and the ALU sequencer.
// Latency: none (wires only).
// Backpressure: start is ignored while the sequencer is busy; psr_update_request stalls PSR_WAIT.
interface alu_sequencer_if;
    logic       start;
    logic [3:0] op;
    logic       acc_mode;
    logic       d_decimal;
    logic       psr_update_request;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] operation_select;
    logic       compute_step;
    logic       acc_to_alu_xfer;
    logic       instruction_decode_in;
    logic       swap_a_b;
    logic       ack_update_request;
    logic       wb_acc;
    logic       wb_mem;

    // Decode side drives requests and observes the strobes.
    modport master (
        output start, op, acc_mode, d_decimal, psr_update_request,
        input  busy, done, err, operation_select, compute_step, acc_to_alu_xfer,
               instruction_decode_in, swap_a_b, ack_update_request, wb_acc, wb_mem
    );

    // Sequencer side.
    modport slave (
        input  start, op, acc_mode, d_decimal, psr_update_request,
        output busy, done, err, operation_select, compute_step, acc_to_alu_xfer,
               instruction_decode_in, swap_a_b, ack_update_request, wb_acc, wb_mem
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation: load, optional swap, BCD convert, compute, PSR handshake, write-back.
// Latency accept->done: binary 4, decimal ADC/SBC 6, accumulator shift 6, +N PSR_WAIT stall cycles.
// Backpressure: start ignored unless IDLE; PSR_WAIT stalls on psr_update_request up to PSR_TIMEOUT.
module alu_sequencer #(
    parameter int PSR_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic             fclk,
    input  logic             resb,
    alu_sequencer_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SWAP_IN, S_TO_BIN, S_COMPUTE,
        S_TO_DEC, S_SWAP_OUT, S_PSR_WAIT, S_DONE
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PSR_TIMEOUT - 1);
    localparam logic [3:0] OP_TO_BIN = 4'hD;
    localparam logic [3:0] OP_TO_DEC = 4'hE;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic             r_acc_mode;
    logic             r_dec;
    logic             r_err;
    logic             r_req_seen;
    logic [TMO_W-1:0] r_cnt;
    logic [3:0]       r_opsel;

    logic w_accept;
    logic w_shift;
    logic w_dec_op;
    logic w_acc_shift;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_shift     = (r_op >= 4'h5) && (r_op <= 4'h8);
    assign w_dec_op    = r_dec && ((r_op == 4'h3) || (r_op == 4'h4));
    assign w_acc_shift = w_shift && r_acc_mode;

    // State register
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_state_nxt = (bus.op >= 4'hD) ? S_DONE : S_LOAD;
            S_LOAD:     w_state_nxt = w_acc_shift ? S_SWAP_IN : (w_dec_op ? S_TO_BIN : S_COMPUTE);
            S_SWAP_IN:  w_state_nxt = S_COMPUTE;
            S_TO_BIN:   w_state_nxt = S_COMPUTE;
            S_COMPUTE:  w_state_nxt = w_dec_op ? S_TO_DEC : (w_acc_shift ? S_SWAP_OUT : S_PSR_WAIT);
            S_TO_DEC:   w_state_nxt = S_PSR_WAIT;
            S_SWAP_OUT: w_state_nxt = S_PSR_WAIT;
            S_PSR_WAIT: if (bus.psr_update_request || (r_cnt == TMO_LAST)) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Capture operation attributes on accept
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            r_op       <= 4'h0;
            r_acc_mode <= 1'b0;
            r_dec      <= 1'b0;
        end else if (w_accept) begin
            r_op       <= bus.op;
            r_acc_mode <= bus.acc_mode;
            r_dec      <= bus.d_decimal;
        end
    end

    // Error / PSR handshake tracking and timeout counter
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            r_err      <= 1'b0;
            r_req_seen <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_err      <= (bus.op >= 4'hD);
                r_req_seen <= 1'b0;
            end
            if (r_state == S_PSR_WAIT) begin
                if (bus.psr_update_request) r_req_seen <= 1'b1;
                else if (r_cnt == TMO_LAST) r_err      <= 1'b1;
                else                        r_cnt      <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // operation_select is registered and holds between compute strobes
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            r_opsel <= 4'h0;
        end else begin
            case (w_state_nxt)
                S_TO_BIN:  r_opsel <= OP_TO_BIN;
                S_COMPUTE: r_opsel <= r_op;
                S_TO_DEC:  r_opsel <= OP_TO_DEC;
                default:   r_opsel <= r_opsel;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        bus.busy                  = (r_state != S_IDLE);
        bus.done                  = (r_state == S_DONE);
        bus.err                   = (r_state == S_DONE) && r_err;
        bus.operation_select      = r_opsel;
        bus.compute_step          = (r_state == S_COMPUTE) || (r_state == S_TO_BIN) || (r_state == S_TO_DEC);
        bus.acc_to_alu_xfer       = (r_state == S_LOAD);
        bus.instruction_decode_in = (r_state == S_LOAD);
        bus.swap_a_b              = (r_state == S_SWAP_IN) || (r_state == S_SWAP_OUT);
        bus.ack_update_request    = (r_state == S_DONE) && r_req_seen;
        bus.wb_acc                = (r_state == S_DONE) && !r_err && ((r_op <= 4'h4) || w_acc_shift);
        bus.wb_mem                = (r_state == S_DONE) && !r_err &&
                                    ((w_shift && !r_acc_mode) || (r_op == 4'hB) || (r_op == 4'hC));
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: runs hand-computed op vectors and checks strobes and timing.
// Latency: checks done cycle counted from the accept edge (cycle 1 = first cycle after accept).
// Backpressure: exercises PSR stall/timeout and start re-pulsed while busy.
module tb_alu_sequencer;
    logic fclk;
    logic resb;
    int   n_checks;
    int   n_errors;

    alu_sequencer_if bus();

    alu_sequencer #(.PSR_TIMEOUT(15), .TMO_W(4)) dut (
        .fclk (fclk),
        .resb (resb),
        .bus  (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Results of the most recent run_op
    int          done_cyc;
    int          n_step;
    int          n_load;
    logic [11:0] opsel_seq;
    logic [31:0] swap_mask;
    logic [31:0] step_mask;
    logic        d_err;
    logic        d_ack;
    logic        d_wb_acc;
    logic        d_wb_mem;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [13:0] all_outs();
        return {bus.busy, bus.done, bus.err, bus.operation_select, bus.compute_step,
                bus.acc_to_alu_xfer, bus.instruction_decode_in, bus.swap_a_b,
                bus.ack_update_request, bus.wb_acc, bus.wb_mem};
    endfunction

    // Issue one operation and trace it until done (bounded). If repulse, start is
    // held high with an illegal op for the whole busy period, including DONE.
    task automatic run_op(input logic [3:0] opc, input logic am, input logic dd,
                          input logic req, input logic repulse);
        done_cyc  = 0;
        n_step    = 0;
        n_load    = 0;
        opsel_seq = '0;
        swap_mask = '0;
        step_mask = '0;
        d_err = 0; d_ack = 0; d_wb_acc = 0; d_wb_mem = 0;
        @(negedge fclk);
        bus.start              = 1'b1;
        bus.op                 = opc;
        bus.acc_mode           = am;
        bus.d_decimal          = dd;
        bus.psr_update_request = req;
        for (int c = 1; c <= 40; c++) begin
            @(negedge fclk);
            if (bus.compute_step) begin
                n_step++;
                opsel_seq = {opsel_seq[7:0], bus.operation_select};
                step_mask[c] = 1'b1;
            end
            if (bus.swap_a_b) swap_mask[c] = 1'b1;
            if (bus.acc_to_alu_xfer || bus.instruction_decode_in) n_load++;
            if (bus.done) begin
                done_cyc = c;
                d_err    = bus.err;
                d_ack    = bus.ack_update_request;
                d_wb_acc = bus.wb_acc;
                d_wb_mem = bus.wb_mem;
                break;
            end
            bus.start = repulse;
            bus.op    = repulse ? 4'hE : opc;
        end
        bus.start = 1'b0;
        if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge fclk);
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resb = 1'b0;
        bus.start = 1'b0;
        bus.op = 4'h0;
        bus.acc_mode = 1'b0;
        bus.d_decimal = 1'b0;
        bus.psr_update_request = 1'b0;
        repeat (3) @(negedge fclk);
        check("reset_outputs", {18'd0, all_outs()}, 32'd0);
        resb = 1'b1;
        @(negedge fclk);
        check("idle_no_start", {18'd0, all_outs()}, 32'd0);

        // AND, request already high
        run_op(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("and_done_cyc", done_cyc, 4);
        check("and_flags", {28'd0, d_err, d_ack, d_wb_acc, d_wb_mem}, 32'b0110);
        check("and_steps", n_step, 1);
        check("and_load", n_load, 1);

        // Decimal ADC
        run_op(4'h3, 1'b0, 1'b1, 1'b1, 1'b0);
        check("adc_dec_seq", {20'd0, opsel_seq}, 32'hD3E);
        check("adc_dec_steps", n_step, 3);
        check("adc_dec_done_cyc", done_cyc, 6);
        check("adc_dec_flags", {28'd0, d_err, d_ack, d_wb_acc, d_wb_mem}, 32'b0110);
        check("opsel_hold", {28'd0, bus.operation_select}, 32'hE);

        // Binary ADC (D=0): no conversion
        run_op(4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("adc_bin_seq", {20'd0, opsel_seq}, 32'h003);
        check("adc_bin_done_cyc", done_cyc, 4);

        // ASL on accumulator: swap at cycles 2 and 4, compute at 3
        run_op(4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("asl_acc_swaps", swap_mask, 32'h14);
        check("asl_acc_step", step_mask, 32'h08);
        check("asl_acc_done_cyc", done_cyc, 6);
        check("asl_acc_wb", {30'd0, d_wb_acc, d_wb_mem}, 32'b10);

        // ASL on memory
        run_op(4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("asl_mem_swaps", swap_mask, 32'h0);
        check("asl_mem_done_cyc", done_cyc, 4);
        check("asl_mem_wb", {30'd0, d_wb_acc, d_wb_mem}, 32'b01);

        // BIT: no write-back; INC-type 0xB: memory write-back
        run_op(4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        check("bit_wb", {29'd0, d_ack, d_wb_acc, d_wb_mem}, 32'b100);
        run_op(4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
        check("opb_wb", {30'd0, d_wb_acc, d_wb_mem}, 32'b01);

        // PSR timeout: 2 cycles + 15 wait + DONE
        run_op(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tmo_done_cyc", done_cyc, 18);
        check("tmo_flags", {28'd0, d_err, d_ack, d_wb_acc, d_wb_mem}, 32'b1000);

        // Illegal op: straight to DONE, no ALU strobes
        run_op(4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ill_done_cyc", done_cyc, 1);
        check("ill_strobes", n_step + n_load + swap_mask, 0);
        check("ill_flags", {28'd0, d_err, d_ack, d_wb_acc, d_wb_mem}, 32'b1000);

        // start re-pulsed with an illegal op while busy and in DONE is ignored
        run_op(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("repulse_done_cyc", done_cyc, 4);
        check("repulse_flags", {28'd0, d_err, d_ack, d_wb_acc, d_wb_mem}, 32'b0110);

        // Reset in COMPUTE (decimal op: LOAD, TO_BIN, COMPUTE)
        @(negedge fclk);
        bus.start = 1'b1; bus.op = 4'h4; bus.d_decimal = 1'b1; bus.acc_mode = 1'b0;
        @(negedge fclk);
        bus.start = 1'b0;
        repeat (2) @(negedge fclk);
        check("rst_pre_compute", {28'd0, bus.operation_select}, 32'h4);
        resb = 1'b0;
        #1;
        check("rst_mid_outputs", {18'd0, all_outs()}, 32'd0);
        @(negedge fclk);
        resb = 1'b1;
        repeat (3) @(negedge fclk);
        check("rst_stays_idle", {18'd0, all_outs()}, 32'd0);
        run_op(4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_done_cyc", done_cyc, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
